// File: rtl/serial_subtractor.sv
// Slice-serial unsigned subtractor: diff = in1 - in2 (mod 2^WIDTH), BITS_PER_CYCLE bits per clock,
// with a registered borrow chain. A one-cycle done pulse marks the result, which holds until the next run.
module serial_subtractor #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int B  = BITS_PER_CYCLE;
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_param
            $error("serial_subtractor: BITS_PER_CYCLE must divide WIDTH exactly");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              load;
    logic              step;
    logic [WIDTH-1:0]  a_sr;
    logic [WIDTH-1:0]  b_sr;
    logic [CW-1:0]     cnt;
    logic              borrow;
    logic [B:0]        slice_sum;
    logic [WIDTH+B-1:0] diff_cat;

    // a - b - borrow done as a + ~b + ~borrow; the slice borrow is the inverted carry
    assign slice_sum = {1'b0, a_sr[B-1:0]} + {1'b0, ~b_sr[B-1:0]} + {{B{1'b0}}, ~borrow};
    assign diff_cat  = {slice_sum[B-1:0], diff};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == CW'(N - 1)) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    next_state = S_RUN;
                end else begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // bout is kept apart from the working borrow so the previous result survives the load cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
        end else if (load) begin
            a_sr   <= in1;
            b_sr   <= in2;
            cnt    <= '0;
            borrow <= 1'b0;
        end else if (step) begin
            a_sr   <= a_sr >> B;
            b_sr   <= b_sr >> B;
            cnt    <= cnt + CW'(1);
            borrow <= ~slice_sum[B];
            diff   <= diff_cat[WIDTH+B-1:B];
            bout   <= ~slice_sum[B];
        end
    end

endmodule
